// File: rtl/average_filter_scheduler.sv
// Round-robin scheduler sharing one two-tap averaging datapath among NUM_CH
// sample streams; each result is tagged with its source channel.
module average_filter_scheduler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_CH-1:0]            i_clear,
  output logic [NUM_CH-1:0]            o_grant,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic [CH_W-1:0]              o_ch,
  output logic                         o_ce,
  input  logic                         i_ready
);

  localparam int unsigned SUM_W  = DATA_WIDTH + 1;
  localparam int unsigned CAND_W = CH_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [CH_W-1:0]               r_last_ch;
  logic signed [DATA_WIDTH-1:0]  r_sample;
  logic signed [DATA_WIDTH-1:0]  r_prev [NUM_CH];
  logic [NUM_CH-1:0]             r_primed;

  logic [CH_W-1:0]               w_win;
  logic                          w_any;
  logic [CAND_W-1:0]             w_cand;
  logic                          w_accept;
  logic                          w_calc;
  logic                          w_xfer;
  logic signed [DATA_WIDTH-1:0]  w_prev_sel;
  logic signed [SUM_W-1:0]       w_sum;
  logic signed [DATA_WIDTH-1:0]  w_result;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_win  = r_last_ch;
    w_any  = 1'b0;
    w_cand = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      w_cand = CAND_W'(r_last_ch) + CAND_W'(i);
      if (w_cand >= CAND_W'(NUM_CH)) begin
        w_cand = w_cand - CAND_W'(NUM_CH);
      end
      if (!w_any && i_req[CH_W'(w_cand)]) begin
        w_win = CH_W'(w_cand);
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_calc      = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_calc      = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (i_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One extra bit of headroom makes the two-tap sum exact; the shift floors.
  assign w_prev_sel = r_prev[r_last_ch];
  assign w_sum      = {w_prev_sel[DATA_WIDTH-1], w_prev_sel} + {r_sample[DATA_WIDTH-1], r_sample};
  assign w_result   = r_primed[r_last_ch] ? w_sum[SUM_W-1:1] : r_sample;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_ch <= CH_W'(NUM_CH - 1);
      r_sample  <= '0;
      r_primed  <= '0;
      o_grant   <= '0;
      o_ce      <= 1'b0;
      data_out  <= '0;
      o_ch      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_prev[i] <= '0;
      end
    end else begin
      o_grant <= '0;
      if (w_accept) begin
        r_sample  <= i_data[w_win*DATA_WIDTH +: DATA_WIDTH];
        r_last_ch <= w_win;
        o_grant   <= {{(NUM_CH-1){1'b0}}, 1'b1} << w_win;
      end
      if (w_calc) begin
        data_out            <= w_result;
        o_ch                <= r_last_ch;
        o_ce                <= 1'b1;
        r_prev[r_last_ch]   <= r_sample;
        r_primed[r_last_ch] <= 1'b1;
      end
      if (w_xfer) begin
        o_ce <= 1'b0;
      end
      // Clears come last so they override a same-edge history update.
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_clear[i]) begin
          r_prev[i]   <= '0;
          r_primed[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/average_filter_scheduler.md
# average_filter_scheduler

Round-robin scheduler that time-shares one two-tap averaging datapath, y = (x[n-1] + x[n]) >>> 1, among NUM_CH independent sample streams. It arbitrates the channel requests, keeps a separate previous-sample register for each channel, computes one average per accepted sample, and tags each result with its source channel. It sits between the multi-channel sample sources and a single downstream consumer that applies backpressure.

## Interface
- DATA_WIDTH, 8, width of signed samples and results
- NUM_CH, 4, number of requesting channels (2..16)
- CH_W, $clog2(NUM_CH), width of the channel tag
- clk  in  1  the single clock; all state changes on the rising edge
- reset_n  in  1  synchronous, active-low reset
- i_req  in  NUM_CH  per-channel request; level-held until that channel sees o_grant
- i_data  in  NUM_CH*DATA_WIDTH  flattened signed samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_clear  in  NUM_CH  per-channel history clear, single-cycle pulse
- o_grant  out  NUM_CH  one-hot, one-cycle pulse: the channel's sample has been captured
- data_out  out  DATA_WIDTH  signed averaged result
- o_ch  out  CH_W  channel tag for data_out
- o_ce  out  1  result valid; held until accepted
- i_ready  in  1  downstream accept; a transfer occurs on an edge where o_ce && i_ready

## Operation
- State machine states: S_IDLE, S_CALC, S_OUT.
- S_IDLE, on an edge where any i_req bit is high:
  - pick the winner by round-robin, searching from last_ch+1 modulo NUM_CH;
  - capture i_data of the winner into the sample register;
  - set last_ch to the winner and pulse o_grant for the winner;
  - go to S_CALC.
- S_IDLE with no request: stay in S_IDLE.
- S_CALC, at the next edge:
  - if the channel is primed, compute sum = sext(prev[ch]) + sext(sample) in DATA_WIDTH+1 bits and take data_out = sum >>> 1, an arithmetic shift that rounds toward negative infinity;
  - if the channel is not primed, data_out = sample;
  - set prev[ch] = sample and primed[ch] = 1, o_ch = ch, o_ce = 1;
  - go to S_OUT.
- Overflow cannot occur. The result always fits in DATA_WIDTH.
- S_OUT: hold data_out, o_ch and o_ce. On an edge with i_ready high, clear o_ce and go to S_IDLE. Requests are ignored in S_CALC and S_OUT.
- i_clear[k] on an edge sets primed[k] = 0 and prev[k] = 0.
  - If this coincides with the S_CALC update of channel k, the clear wins.
  - The result computed on that edge still uses the old prev[k].
- A requester may change i_data or drop i_req during its o_grant cycle. An i_req still high in S_IDLE is treated as a new sample.
- Reset values: state S_IDLE, o_grant 0, o_ce 0, data_out 0, o_ch 0, all prev 0, all primed 0, last_ch NUM_CH-1 (so channel 0 has first priority).
- Reset asserted in any state clears everything on that edge. A pending result is discarded and not delivered.

## Timing
- Take E0 as the edge that samples a request in S_IDLE.
- o_grant is high in the cycle after E0.
- The result is registered at E0+1, and o_ce is high from E0+1.
- With i_ready held high, the transfer happens at E0+2, the next request is sampled at E0+3, and peak throughput is one sample per 3 cycles.
- Each cycle of i_ready low extends S_OUT by one cycle. No grants are issued while stalled.
- o_grant is never asserted in the same cycle as an o_ce transfer for a different sample.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Channel 0 alone, i_ready=1, samples 10, -20, 30, -40 -> data_out 10, -5, 5, -5, all with o_ch=0; o_grant[0] exactly 3 cycles apart.
- Rounding:
  - channel 1 samples 100 then -127 -> 100, then -14 (floor of -13.5);
  - channel 2 samples 127 then -60 -> 127, then 33.
- Round-robin: all four i_req held high with distinct samples -> grant order 0,1,2,3,0,1; each channel's second output averages only its own samples.
- Backpressure: result pending with i_ready low for 5 cycles -> data_out, o_ch and o_ce stable throughout with no o_grant pulses; on release, one transfer occurs, then arbitration resumes.
- Clear: channel 0 samples 50, then i_clear[0] pulse, then sample 0 -> outputs 50 then 0 (not 25).
- Reset in S_OUT:
  - o_ce is 0 the cycle after the reset edge and the result is never accepted;
  - after release, channel 0 sample 40 -> output 40 (unprimed) from channel 0.
